apb4_regbank: RTL and testbench

Parametrised APB4 slave with an integrated register bank. It generalises the current fixed 16-register slave with:
- configurable register count, stride and base address;
- programmable wait states;
- PSTRB byte-lane writes;
- read-only status registers fed from hardware;
- PSLVERR error responses.

It sits behind the APB interconnect as one peripheral slot and exports register contents and write pulses to the block it controls.

---
 rtl/apb4_regbank.sv | 151 +++++++++++++++
 tb/tb_apb4_regbank.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_regbank.sv
// rtl/apb4_regbank.sv - Parametrised APB4 slave with byte-strobed RW registers and hardware-fed RO registers
module apb4_regbank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    NUM_REGS    = 16,
    parameter int                    ADDR_STRIDE = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int                    NB          = DATA_WIDTH / 8;
    localparam int                    SHIFT       = $clog2(ADDR_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_MASK = ADDR_WIDTH'(ADDR_STRIDE - 1);
    localparam logic [3:0]            WS          = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    dec_wr;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    ro_hit;
    logic                    dec_err;
    logic [NUM_REGS-1:0]     sel;
    logic [DATA_WIDTH-1:0]   rd_value;
    logic                    access;
    logic                    commit;

    // In IDLE the decode looks at the live bus so a zero-wait transfer can register its response at the setup edge.
    assign dec_addr     = (state == S_IDLE) ? PADDR  : addr_q;
    assign dec_wr       = (state == S_IDLE) ? PWRITE : wr_q;
    assign off          = dec_addr - BASE_ADDR;
    assign idx          = off >> SHIFT;
    assign misaligned   = |(off & STRIDE_MASK);
    assign out_of_range = (idx >= ADDR_WIDTH'(NUM_REGS));

    always_comb begin
        sel      = '0;
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!misaligned && idx == ADDR_WIDTH'(i)) begin
                sel[i]   = 1'b1;
                rd_value = RO_MASK[i] ? hw_status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    assign ro_hit  = |(sel & RO_MASK);
    assign dec_err = misaligned | out_of_range | (dec_wr & ro_hit);
    assign access  = PSEL & PENABLE;
    assign commit  = (state == S_RESP) & access & wr_q & ~PSLVERR;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            PREADY     <= 1'b0;
            PRDATA     <= '0;
            PSLVERR    <= 1'b0;
            wr_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            PREADY     <= 1'b0;
            PRDATA     <= '0;
            PSLVERR    <= 1'b0;
            wr_pulse_o <= '0;
            case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        wr_q    <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        if (WS == 4'd0) begin
                            state   <= S_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= dec_err;
                            PRDATA  <= dec_err ? '0 : rd_value;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WS;
                        end
                    end
                end
                S_WAIT: begin
                    if (!access) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd1) begin
                        state   <= S_RESP;
                        PREADY  <= 1'b1;
                        PSLVERR <= dec_err;
                        PRDATA  <= dec_err ? '0 : rd_value;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (commit) begin
                        wr_pulse_o <= sel;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            for (int b = 0; b < NB; b++) begin
                                if (sel[i] && strb_q[b]) begin
                                    regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                                end
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

endmodule

// File: tb/tb_apb4_regbank.sv
// tb/tb_apb4_regbank.sv - Self-checking bench for apb4_regbank against an array-based register model
module tb_apb4_regbank;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NR = 16;
    localparam int WS = 2;
    localparam logic [NR-1:0] ROM = 16'h0001;

    logic              clk = 1'b0;
    logic              PRESETn;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [3:0]        PSTRB;
    logic              PREADY;
    logic [DW-1:0]     PRDATA;
    logic              PSLVERR;
    logic [NR*DW-1:0]  hw_status;
    logic [NR*DW-1:0]  reg_q_o;
    logic [NR-1:0]     wr_pulse_o;

    logic [DW-1:0]     model  [NR];
    logic [DW-1:0]     hw_arr [NR];
    int                total = 0;
    int                bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        hw_status = '0;
        for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = hw_arr[i];
    end

    apb4_regbank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .ADDR_STRIDE(64),
        .BASE_ADDR(16'h0000), .WAIT_STATES(WS), .RO_MASK(ROM)
    ) dut (
        .PCLK(clk), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .hw_status_i(hw_status), .reg_q_o(reg_q_o), .wr_pulse_o(wr_pulse_o)
    );

    function automatic logic exp_err(input logic wr, input logic [AW-1:0] a);
        int off;
        logic [3:0] ix;
        off = int'(a);
        if (off % 64 != 0) return 1'b1;
        if (off / 64 >= NR) return 1'b1;
        ix = 4'(off / 64);
        if (wr && ROM[ix]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        logic [3:0] ix;
        if (exp_err(1'b0, a)) return '0;
        ix = 4'(int'(a) / 64);
        return ROM[ix] ? hw_arr[ix] : model[ix];
    endfunction

    function automatic logic [NR-1:0] exp_pulse(input logic wr, input logic [AW-1:0] a);
        if (!wr || exp_err(wr, a)) return '0;
        return NR'(1) << (int'(a) / 64);
    endfunction

    function automatic logic [NR*DW-1:0] exp_regq();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) if (!ROM[i]) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int ix;
        if (exp_err(1'b1, a)) return;
        ix = int'(a) / 64;
        for (int b = 0; b < 4; b++) if (s[b]) model[ix][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // Called at posedge+1; drives the setup phase immediately and returns at posedge+1 of the cycle after PREADY.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, output logic [DW-1:0] rd, output logic er,
                            output int cyc, output logic [NR-1:0] pulse);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        rd = '0; er = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (PREADY === 1'b1) begin
                rd = PRDATA;
                er = PSLVERR;
                break;
            end
            if (cyc >= 20) break;
        end
        @(posedge clk); #1;
        pulse = wr_pulse_o;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL reset_pready: got %b want 0", PREADY); end
        total++; if (PRDATA !== '0) begin bad++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
        total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
        total++; if (wr_pulse_o !== '0) begin bad++; $display("FAIL reset_pulse: got %h want 0", wr_pulse_o); end
        total++; if (reg_q_o !== '0) begin bad++; $display("FAIL reset_regq: got %h want 0", reg_q_o); end
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        apb_xfer(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, rd, er, cyc, p);
        model_write(16'h0040, 32'hDEADBEEF, 4'hF);
        total++; if (cyc != WS + 1) begin bad++; $display("FAIL wr_latency: got %0d want %0d", cyc, WS + 1); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", er); end
        total++; if (p !== 16'h0002) begin bad++; $display("FAIL wr_pulse: got %h want 0002", p); end
        tick();
        total++; if (wr_pulse_o !== '0) begin bad++; $display("FAIL wr_pulse_len: got %h want 0", wr_pulse_o); end
        apb_xfer(1'b0, 16'h0040, '0, 4'h0, rd, er, cyc, p);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_back: got %h want deadbeef", rd); end
        total++; if (cyc != WS + 1) begin bad++; $display("FAIL rd_latency: got %0d want %0d", cyc, WS + 1); end
        tick();
    endtask

    task automatic test_strobe();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        apb_xfer(1'b1, 16'h0040, 32'h0000AB00, 4'b0010, rd, er, cyc, p);
        model_write(16'h0040, 32'h0000AB00, 4'b0010);
        total++; if (p !== 16'h0002) begin bad++; $display("FAIL strb_pulse: got %h want 0002", p); end
        apb_xfer(1'b0, 16'h0040, '0, 4'hF, rd, er, cyc, p);
        total++; if (rd !== 32'hDEADABEF) begin bad++; $display("FAIL strb_read: got %h want deadabef", rd); end
        total++; if (reg_q_o !== exp_regq()) begin bad++; $display("FAIL strb_regq: got %h want %h", reg_q_o, exp_regq()); end
        apb_xfer(1'b1, 16'h0040, 32'h55555555, 4'b0000, rd, er, cyc, p);
        total++; if (p !== 16'h0002) begin bad++; $display("FAIL strb0_pulse: got %h want 0002", p); end
        total++; if (reg_q_o[1*DW +: DW] !== 32'hDEADABEF) begin bad++; $display("FAIL strb0_data: got %h want deadabef", reg_q_o[1*DW +: DW]); end
        tick();
    endtask

    task automatic test_ro();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        hw_arr[0] = 32'h12345678;
        apb_xfer(1'b1, 16'h0000, 32'hFFFFFFFF, 4'hF, rd, er, cyc, p);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL ro_wr_err: got %b want 1", er); end
        total++; if (p !== '0) begin bad++; $display("FAIL ro_wr_pulse: got %h want 0", p); end
        tick();
        apb_xfer(1'b0, 16'h0000, '0, 4'h0, rd, er, cyc, p);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL ro_read: got %h want 12345678", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL ro_rd_err: got %b want 0", er); end
        tick();
    endtask

    task automatic test_decode_err();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        logic [AW-1:0] addrs [2];
        addrs[0] = 16'h0044;
        addrs[1] = 16'h0400;
        for (int k = 0; k < 2; k++) begin
            apb_xfer(1'b0, addrs[k], '0, 4'h0, rd, er, cyc, p);
            total++; if (er !== 1'b1) begin bad++; $display("FAIL dec_rd_err %h: got %b want 1", addrs[k], er); end
            total++; if (rd !== '0) begin bad++; $display("FAIL dec_rd_data %h: got %h want 0", addrs[k], rd); end
            apb_xfer(1'b1, addrs[k], 32'hA5A5A5A5, 4'hF, rd, er, cyc, p);
            total++; if (er !== 1'b1) begin bad++; $display("FAIL dec_wr_err %h: got %b want 1", addrs[k], er); end
            total++; if (p !== '0) begin bad++; $display("FAIL dec_wr_pulse %h: got %h want 0", addrs[k], p); end
            total++; if (reg_q_o !== exp_regq()) begin bad++; $display("FAIL dec_regq %h: got %h want %h", addrs[k], reg_q_o, exp_regq()); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        logic seen;
        apb_xfer(1'b1, 16'h00C0, 32'h00000011, 4'hF, rd, er, cyc, p);
        model_write(16'h00C0, 32'h00000011, 4'hF);
        apb_xfer(1'b0, 16'h00C0, '0, 4'h0, rd, er, cyc, p);
        total++; if (rd !== 32'h00000011) begin bad++; $display("FAIL b2b_read: got %h want 00000011", rd); end
        total++; if (cyc != WS + 1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, WS + 1); end
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h00C0; PWDATA = 32'h00000022; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (PREADY !== 1'b0 || wr_pulse_o !== '0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_activity: got %b want 0", seen); end
        total++; if (reg_q_o[3*DW +: DW] !== model[3]) begin bad++; $display("FAIL abort_data: got %h want %h", reg_q_o[3*DW +: DW], model[3]); end
        tick();
        apb_xfer(1'b0, 16'h00C0, '0, 4'h0, rd, er, cyc, p);
        total++; if (rd !== 32'h00000011 || cyc != WS + 1) begin bad++; $display("FAIL abort_recover: got %h/%0d want 00000011/%0d", rd, cyc, WS + 1); end
        tick();
    endtask

    task automatic test_reset_midway();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        int n;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0080; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        @(negedge clk);
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL rst_wait_pready: got %b want 0", PREADY); end
        total++; if (reg_q_o !== '0) begin bad++; $display("FAIL rst_wait_regq: got %h want 0", reg_q_o); end
        tick();
        PRESETn = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0080; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        tick();
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (PREADY !== 1'b1 && n < 20);
        total++; if (n != WS + 1) begin bad++; $display("FAIL rst_resp_reach: got %0d want %0d", n, WS + 1); end
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL rst_resp_pready: got %b want 0", PREADY); end
        tick();
        total++; if (reg_q_o[2*DW +: DW] !== '0 || wr_pulse_o !== '0) begin bad++; $display("FAIL rst_resp_commit: got %h/%h want 0/0", reg_q_o[2*DW +: DW], wr_pulse_o); end
        PRESETn = 1'b1;
        tick();
        apb_xfer(1'b1, 16'h0080, 32'h0BADC0DE, 4'hF, rd, er, cyc, p);
        model_write(16'h0080, 32'h0BADC0DE, 4'hF);
        total++; if (er !== 1'b0 || p !== 16'h0004) begin bad++; $display("FAIL rst_after_wr: got %b/%h want 0/0004", er, p); end
        total++; if (reg_q_o !== exp_regq()) begin bad++; $display("FAIL rst_after_regq: got %h want %h", reg_q_o, exp_regq()); end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] rd; logic er; int cyc; logic [NR-1:0] p;
        logic wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] s;
        logic [DW-1:0] e_rd; logic e_er; logic [NR-1:0] e_p;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) hw_arr[$urandom_range(0, NR - 1)] = $urandom;
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    a = 16'($urandom_range(0, 15) * 64);
                2:       a = 16'($urandom_range(0, 15) * 64 + $urandom_range(1, 63));
                default: a = 16'($urandom_range(16, 1023) * 64);
            endcase
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            e_rd = exp_read(a);
            e_er = exp_err(wr, a);
            e_p  = exp_pulse(wr, a);
            apb_xfer(wr, a, d, s, rd, er, cyc, p);
            if (wr) model_write(a, d, s);
            total++; if (er !== e_er) begin bad++; $display("FAIL rnd_err #%0d a=%h w=%b: got %b want %b", k, a, wr, er, e_er); end
            total++; if (cyc != WS + 1) begin bad++; $display("FAIL rnd_latency #%0d: got %0d want %0d", k, cyc, WS + 1); end
            total++; if (p !== e_p) begin bad++; $display("FAIL rnd_pulse #%0d a=%h: got %h want %h", k, a, p, e_p); end
            if (!wr) begin
                total++; if (rd !== e_rd) begin bad++; $display("FAIL rnd_rdata #%0d a=%h: got %h want %h", k, a, rd, e_rd); end
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        total++; if (reg_q_o !== exp_regq()) begin bad++; $display("FAIL rnd_regq: got %h want %h", reg_q_o, exp_regq()); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            model[i]  = '0;
            hw_arr[i] = '0;
        end
        test_reset();
        test_write_read();
        test_strobe();
        test_ro();
        test_decode_err();
        test_back_to_back();
        test_reset_midway();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
